// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the sequential multiplier.
package mult_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mult_pkg

// File: rtl/mult_step.sv
// One radix-2 multiply step on {A,Q,q_1}; MULT_SIGNED_EN selects Booth over
// unsigned shift-add.
module mult_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q1_o
);

  logic [WIDTH:0] sum_c;

`ifdef MULT_SIGNED_EN
  // Booth recoding on {Q[0],q_1}, then arithmetic shift of {A,Q,q_1}
  always_comb begin
    unique case ({q_i[0], q1_i})
      2'b01:   sum_c = a_i + m_i;
      2'b10:   sum_c = a_i - m_i;
      default: sum_c = a_i;
    endcase
    a_o  = {sum_c[WIDTH], sum_c[WIDTH:1]};
    q_o  = {sum_c[0], q_i[WIDTH-1:1]};
    q1_o = q_i[0];
  end
`else
  // Add multiplicand on Q[0], carry lands in A[WIDTH], then logical shift of {A,Q}
  always_comb begin
    sum_c = q_i[0] ? (a_i + m_i) : a_i;
    a_o   = {1'b0, sum_c[WIDTH:1]};
    q_o   = {sum_c[0], q_i[WIDTH-1:1]};
    q1_o  = q1_i;
  end
`endif

endmodule : mult_step

// File: rtl/mult.sv
// Sequential WIDTHxWIDTH multiplier, one step per cycle, result in hi/lo.
// Define MULT_SIGNED_EN for a two's-complement (Booth) build; unsigned otherwise.
module mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             multCtrl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             multDone
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_pkg::state_e state_q, state_d;

  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   m_ext_c;
  logic [WIDTH:0]   a_step_c;
  logic [WIDTH-1:0] q_step_c;
  logic             q1_step_c;

`ifdef MULT_SIGNED_EN
  assign m_ext_c = {srcA[WIDTH-1], srcA};
`else
  assign m_ext_c = {1'b0, srcA};
`endif

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (a_step_c),
    .q_o  (q_step_c),
    .q1_o (q1_step_c)
  );

  // Next-state: multCtrl reloads from any state, otherwise RUN steps until the last count
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = done_q;

    if (multCtrl) begin
      state_d = mult_pkg::RUN;
      m_d     = m_ext_c;
      a_d     = '0;
      q_d     = srcB;
      q1_d    = 1'b0;
      cnt_d   = '0;
      hi_d    = '0;
      lo_d    = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        mult_pkg::RUN: begin
          a_d   = a_step_c;
          q_d   = q_step_c;
          q1_d  = q1_step_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            hi_d    = a_step_c[WIDTH-1:0];
            lo_d    = q_step_c;
            done_d  = 1'b1;
            state_d = mult_pkg::DONE;
          end
        end
        mult_pkg::IDLE,
        mult_pkg::DONE: ;
        default: state_d = mult_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= mult_pkg::IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign multDone = done_q;

endmodule : mult

// File: tb/tb_mult.sv
// Self-checking bench for mult: directed table, multi-cycle corner sequences,
// and random operands against a plain-arithmetic product model.
module tb_mult;

  logic        clk;
  logic        reset;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        multCtrl;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        multDone;

  int n_cmp = 0;
  int n_bad = 0;

  mult #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .srcA     (srcA),
    .srcB     (srcB),
    .multCtrl (multCtrl),
    .hi       (hi),
    .lo       (lo),
    .multDone (multDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic cmp(input string name, input logic [64:0] got, input logic [64:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%h want 0x%h", name, got, want);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    logic [63:0] ua;
    logic [63:0] ub;
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
`endif
  endfunction

  // Hold multCtrl for 'hold' edges; returns just after the last load edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b, input int hold);
    @(negedge clk);
    srcA     = a;
    srcB     = b;
    multCtrl = 1'b1;
    repeat (hold) @(negedge clk);
    multCtrl = 1'b0;
  endtask

  // Outputs must read 0 until exactly 32 edges after the load edge, then hold the product.
  task automatic finish_check(input string name, input logic [63:0] exp);
    int bad;
    bad = 0;
    cmp({name, "/load_clear"}, {multDone, hi, lo}, 65'd0);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (k < 32 && (multDone !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)) bad++;
    end
    cmp({name, "/interim"}, 65'(bad), 65'd0);
    cmp({name, "/result"}, {multDone, hi, lo}, {1'b1, exp});
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra;
    logic [31:0] rb;

    tbl[0] = '{a: 32'd3,        b: 32'd5,        hold: 1, exp: 64'd15};
    tbl[1] = '{a: 32'd0,        b: 32'h12345678, hold: 1, exp: 64'd0};
    tbl[2] = '{a: 32'd100000,   b: 32'd100000,   hold: 4, exp: 64'd10000000000};
    tbl[3] = '{a: 32'h80000000, b: 32'h80000000, hold: 1, exp: 64'h40000000_00000000};
`ifdef MULT_SIGNED_EN
    tbl[4] = '{a: 32'hFFFFFFF9, b: 32'd6,        hold: 1, exp: 64'hFFFFFFFF_FFFFFFD6};
    tbl[5] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hold: 1, exp: 64'h00000000_00000001};
    tbl[6] = '{a: 32'h7FFFFFFF, b: 32'h80000000, hold: 2, exp: 64'hC0000000_80000000};
`else
    tbl[4] = '{a: 32'hFFFFFFF9, b: 32'd6,        hold: 1, exp: 64'h00000005_FFFFFFD6};
    tbl[5] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hold: 1, exp: 64'hFFFFFFFE_00000001};
    tbl[6] = '{a: 32'h7FFFFFFF, b: 32'h80000000, hold: 2, exp: 64'h3FFFFFFF_80000000};
`endif

    // Reset with multCtrl high: reset wins, nothing starts afterwards.
    reset    = 1'b0;
    multCtrl = 1'b1;
    srcA     = 32'd3;
    srcB     = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_state", {multDone, hi, lo}, 65'd0);
    @(negedge clk);
    reset    = 1'b1;
    multCtrl = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (multDone) done_seen++;
    end
    cmp("reset_priority", 65'(done_seen), 65'd0);

    // Directed table, then the level must persist.
    foreach (tbl[i]) begin
      start(tbl[i].a, tbl[i].b, tbl[i].hold);
      finish_check($sformatf("vec%0d", i), tbl[i].exp);
    end
    repeat (3) @(posedge clk);
    #1;
    cmp("done_level_hold", {multDone, hi, lo}, {1'b1, tbl[6].exp});

    // Restart at step 10 discards 3x5 and yields 2x4.
    start(32'd3, 32'd5, 1);
    done_seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (multDone) done_seen++;
    end
    cmp("restart/early_done", 65'(done_seen), 65'd0);
    start(32'd2, 32'd4, 1);
    finish_check("restart", 64'd8);

    // Reset while DONE clears the outputs on that edge.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cmp("reset_in_done", {multDone, hi, lo}, 65'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset at step 20 aborts the run; a fresh 7x7 then completes.
    start(32'd9, 32'd11, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cmp("reset_in_run", {multDone, hi, lo}, 65'd0);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (multDone) done_seen++;
    end
    cmp("reset_in_run/aborted", 65'(done_seen), 65'd0);
    start(32'd7, 32'd7, 1);
    finish_check("after_reset", 64'd49);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h80000000;
      if (i == 1) rb = 32'h7FFFFFFF;
      start(ra, rb, 1 + (i % 3));
      finish_check($sformatf("rand%0d_%h_%h", i, ra, rb), ref_mul(ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mult
